mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Single-port data-memory arbiter between the pipeline MEM stage and a debug/loader port. The block sits between the MEM stage and the 2**ADDR_SIZE x WORD_SIZE data RAM. It multiplexes address, write data and enables onto the RAM and stalls the pipeline when the debug port wins. A starvation counter guarantees the debug port forward progress. A lock mode gives the loader exclusive ownership for bursts.

## Interface
- ADDR_SIZE, 10, RAM word-address width
- WORD_SIZE, 32, data width
- STARVE_LIMIT, 4, consecutive denied debug cycles before debug is forced to win (legal range 1..255)

- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- cpu_req  in  1  MEM stage requests a RAM access this cycle
- cpu_we  in  1  MEM access is a store
- cpu_addr  in  ADDR_SIZE  MEM word address
- cpu_wdata  in  WORD_SIZE  MEM store data
- cpu_stall  out  1  hold EX/MEM registers; the access is not performed this cycle
- cpu_rdata  out  WORD_SIZE  load data, valid the cycle after a granted CPU read
- dbg_req  in  1  debug access request; held until dbg_gnt
- dbg_we  in  1  debug access is a write
- dbg_lock  in  1  request exclusive ownership for a burst
- dbg_addr  in  ADDR_SIZE  debug word address
- dbg_wdata  in  WORD_SIZE  debug write data
- dbg_gnt  out  1  debug access performed this cycle
- dbg_rdata  out  WORD_SIZE  debug read data, qualified by dbg_rvalid
- dbg_rvalid  out  1  dbg_rdata is valid (one cycle after a granted debug read)
- mem_en  out  1  RAM access enable
- mem_we  out  1  RAM write enable
- mem_addr  out  ADDR_SIZE  RAM address
- mem_wdata  out  WORD_SIZE  RAM write data
- mem_rdata  in  WORD_SIZE  RAM synchronous read data (1-cycle latency)

## Operation
- State register `arb_state` has two states:
  - IDLE: CPU has priority.
  - LOCK: debug owns the RAM exclusively.
- The saturating counter `starve_cnt` has width ceil(log2(STARVE_LIMIT+1)).
- Debug wins (combinational, same cycle) when dbg_req AND (arb_state==LOCK OR !cpu_req OR starve_cnt==STARVE_LIMIT).
- dbg_gnt = debug wins.
- cpu_stall = cpu_req AND debug wins.
- In LOCK with dbg_req low, the RAM is idle: mem_en=0, and cpu_stall = cpu_req.
- RAM mux:
  - When debug wins, mem_* are driven from dbg_*.
  - Otherwise, when cpu_req is high, mem_* are driven from cpu_*.
  - mem_en = granted request present.
  - mem_we = the winner's we AND mem_en.
  - Inactive mem_addr/mem_wdata are 0.
- starve_cnt:
  - Cleared when dbg_gnt or !dbg_req.
  - Otherwise increments, saturating at STARVE_LIMIT.
- State transitions:
  - IDLE -> LOCK when dbg_gnt AND dbg_lock.
  - LOCK -> IDLE when !dbg_lock, evaluated every cycle.
- dbg_lock is ignored unless it arrives with a granted request.
- Read return:
  - Register `rd_owner` records the winner of a granted read: 0 = CPU, 1 = debug.
  - dbg_rvalid <= dbg_gnt AND !dbg_we.
  - dbg_rdata = mem_rdata when dbg_rvalid, else 0.
  - cpu_rdata = mem_rdata when the previous cycle was a granted CPU read, else 0.
- Same-address conflict: a stalled CPU store retries after the debug write. The final RAM contents are therefore the CPU data.
- The address-decoded IO window is outside this block. The MEM stage does not raise cpu_req for IO accesses.

## Timing
- Reset (asynchronous assert, synchronous release):
  - arb_state=IDLE, starve_cnt=0, rd_owner=0, dbg_rvalid=0.
  - All combinational outputs are therefore 0 while the request inputs are low.
- Grant and stall: 0-cycle latency, combinational from inputs plus registered state.
- Read data: 1 cycle after the grant.
- Worst-case debug wait under continuous cpu_req: STARVE_LIMIT cycles. The grant comes on cycle STARVE_LIMIT+1 of dbg_req.
- Worst-case CPU stall outside LOCK: 1 cycle per debug access.
- In LOCK, the CPU stalls for the whole burst, every cycle including idle ones.
- Reset mid-LOCK returns to IDLE. Any pending dbg_rvalid is dropped.
- Debug request inputs must be stable while dbg_req is high and not granted.

## Test plan
- Reset: assert rst_n=0 with dbg_req=1 and cpu_req=1 -> all outputs 0. Release -> CPU wins the first cycle, and starve_cnt starts counting.
- Starvation: cpu_req held high, dbg read of addr 0x3 (RAM holds 0xDEADBEEF), STARVE_LIMIT=4:
  - dbg_gnt and cpu_stall go high in cycle 5 only.
  - dbg_rvalid=1 with dbg_rdata=0xDEADBEEF in cycle 6.
- Idle CPU: cpu_req=0, dbg write 0x12345678 to 0x10 -> granted the same cycle. A following CPU load of 0x10 returns 0x12345678 one cycle later.
- Lock burst: dbg_lock=1 with 8 writes to 0x20..0x27, with cpu_req high throughout:
  - cpu_stall stays high on every cycle including gaps.
  - After dbg_lock drops, the next cycle the CPU wins and cpu_stall=0.
- Conflict: same-cycle CPU store 0xA and forced debug store 0xB to 0x5 -> RAM[0x5]=0xA after the CPU retry. cpu_stall is high for exactly 1 cycle.
- Reset mid-LOCK after a granted debug read -> dbg_rvalid=0 and arb_state=IDLE. The CPU is granted on the first cycle after release.

Source files
------------

// File: rtl/mem_arbiter.sv
`timescale 1ns/1ps
// Single-port data-RAM arbiter between the pipeline MEM stage and a debug/loader port.
// CPU has priority; a starvation counter forces debug through, and a lock mode hands the loader the RAM.
module mem_arbiter #(
  parameter int ADDR_SIZE    = 10,
  parameter int WORD_SIZE    = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cpu_req,
  input  logic                 cpu_we,
  input  logic [ADDR_SIZE-1:0] cpu_addr,
  input  logic [WORD_SIZE-1:0] cpu_wdata,
  output logic                 cpu_stall,
  output logic [WORD_SIZE-1:0] cpu_rdata,
  input  logic                 dbg_req,
  input  logic                 dbg_we,
  input  logic                 dbg_lock,
  input  logic [ADDR_SIZE-1:0] dbg_addr,
  input  logic [WORD_SIZE-1:0] dbg_wdata,
  output logic                 dbg_gnt,
  output logic [WORD_SIZE-1:0] dbg_rdata,
  output logic                 dbg_rvalid,
  output logic                 mem_en,
  output logic                 mem_we,
  output logic [ADDR_SIZE-1:0] mem_addr,
  output logic [WORD_SIZE-1:0] mem_wdata,
  input  logic [WORD_SIZE-1:0] mem_rdata
);

  localparam int               CNT_W   = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

  typedef enum logic {
    IDLE = 1'b0,
    LOCK = 1'b1
  } arb_state_t;

  arb_state_t       arb_state;
  logic [CNT_W-1:0] starve_cnt;
  logic             rd_owner;
  logic             rd_vld_p1;

  logic cpu_req_v;
  logic dbg_req_v;
  logic locked;
  logic dbg_win;
  logic cpu_win;
  logic rd_gnt;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + 1'b1;
  endfunction

  // ---- stage p0: combinational arbitration against registered state ----
  // Requests are masked while reset is held so every output reads 0 during reset.
  assign cpu_req_v = cpu_req & rst_n;
  assign dbg_req_v = dbg_req & rst_n;
  assign locked    = (arb_state == LOCK);

  assign dbg_win = dbg_req_v & (locked | ~cpu_req_v | (starve_cnt == CNT_MAX));
  assign cpu_win = cpu_req_v & ~dbg_win & ~locked;
  assign rd_gnt  = (dbg_win & ~dbg_we) | (cpu_win & ~cpu_we);

  assign dbg_gnt   = dbg_win;
  assign cpu_stall = cpu_req_v & ~cpu_win;

  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (dbg_win) begin
      mem_en    = 1'b1;
      mem_we    = dbg_we;
      mem_addr  = dbg_addr;
      mem_wdata = dbg_wdata;
    end else if (cpu_win) begin
      mem_en    = 1'b1;
      mem_we    = cpu_we;
      mem_addr  = cpu_addr;
      mem_wdata = cpu_wdata;
    end
  end

  // ---- stage p0 -> p1: arbitration state and read-return tracking ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      arb_state  <= IDLE;
      starve_cnt <= '0;
      rd_owner   <= 1'b0;
      rd_vld_p1  <= 1'b0;
    end else begin
      case (arb_state)
        IDLE:    if (dbg_win && dbg_lock) arb_state <= LOCK;
        LOCK:    if (!dbg_lock) arb_state <= IDLE;
        default: arb_state <= IDLE;
      endcase

      if (dbg_win || !dbg_req_v) starve_cnt <= '0;
      else                       starve_cnt <= sat_inc(starve_cnt);

      rd_vld_p1 <= rd_gnt;
      if (rd_gnt) rd_owner <= dbg_win;
    end
  end

  // ---- stage p1: steer the RAM's registered read data to its owner ----
  assign dbg_rvalid = rd_vld_p1 & rd_owner;
  assign dbg_rdata  = dbg_rvalid ? mem_rdata : '0;
  assign cpu_rdata  = (rd_vld_p1 && !rd_owner) ? mem_rdata : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
`timescale 1ns/1ps
// Randomised and directed bench for mem_arbiter with a behavioural arbitration model and RAM.
module tb_mem_arbiter;
  localparam int AW = 10;
  localparam int DW = 32;
  localparam int SL = 4;

  logic          clk;
  logic          rst_n;
  logic          cpu_req, cpu_we;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic          cpu_stall;
  logic [DW-1:0] cpu_rdata;
  logic          dbg_req, dbg_we, dbg_lock;
  logic [AW-1:0] dbg_addr;
  logic [DW-1:0] dbg_wdata;
  logic          dbg_gnt;
  logic [DW-1:0] dbg_rdata;
  logic          dbg_rvalid;
  logic          mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  int n_vec = 0;
  int n_err = 0;

  mem_arbiter #(.ADDR_SIZE(AW), .WORD_SIZE(DW), .STARVE_LIMIT(SL)) dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_stall(cpu_stall), .cpu_rdata(cpu_rdata),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_lock(dbg_lock), .dbg_addr(dbg_addr),
    .dbg_wdata(dbg_wdata), .dbg_gnt(dbg_gnt), .dbg_rdata(dbg_rdata), .dbg_rvalid(dbg_rvalid),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous RAM attached to the arbiter
  logic [DW-1:0] ram [0:(1<<AW)-1];
  initial mem_rdata = '0;
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      else        mem_rdata     <= ram[mem_addr];
    end
  end

  function automatic logic [DW-1:0] init_val(input int i);
    return 32'h5A5A_0000 ^ (32'(i) * 32'h0001_0203);
  endfunction

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  // Behavioural model: who may use the RAM this cycle, and what read data is owed next cycle
  bit            m_locked = 1'b0;
  int            m_wait = 0;
  int            m_rd_kind = 0;      // 0 none, 1 cpu, 2 debug
  logic [DW-1:0] m_rd_data = '0;
  logic [DW-1:0] m_mem [0:(1<<AW)-1];

  logic          e_dw, e_cw, e_stall, e_en, e_we, e_rv;
  logic [AW-1:0] e_addr;
  logic [DW-1:0] e_wd, e_dr, e_cr;

  initial forever begin
    @(negedge clk);
    if (!rst_n) begin
      e_dw = 0; e_cw = 0; e_stall = 0; e_en = 0; e_we = 0; e_rv = 0;
      e_addr = '0; e_wd = '0; e_dr = '0; e_cr = '0;
    end else begin
      e_dw    = dbg_req && (m_locked || !cpu_req || m_wait >= SL);
      e_cw    = cpu_req && !e_dw && !m_locked;
      e_stall = cpu_req && !e_cw;
      if (e_dw) begin
        e_en = 1; e_we = dbg_we; e_addr = dbg_addr; e_wd = dbg_wdata;
      end else if (e_cw) begin
        e_en = 1; e_we = cpu_we; e_addr = cpu_addr; e_wd = cpu_wdata;
      end else begin
        e_en = 0; e_we = 0; e_addr = '0; e_wd = '0;
      end
      e_rv = (m_rd_kind == 2);
      e_dr = e_rv ? m_rd_data : '0;
      e_cr = (m_rd_kind == 1) ? m_rd_data : '0;
    end
    check("dbg_gnt",    32'(dbg_gnt),    32'(e_dw));
    check("cpu_stall",  32'(cpu_stall),  32'(e_stall));
    check("mem_en",     32'(mem_en),     32'(e_en));
    check("mem_we",     32'(mem_we),     32'(e_we));
    check("mem_addr",   32'(mem_addr),   32'(e_addr));
    check("mem_wdata",  mem_wdata,       e_wd);
    check("dbg_rvalid", 32'(dbg_rvalid), 32'(e_rv));
    check("dbg_rdata",  dbg_rdata,       e_dr);
    check("cpu_rdata",  cpu_rdata,       e_cr);
    if (!rst_n) begin
      m_locked = 0; m_wait = 0; m_rd_kind = 0;
    end else begin
      m_rd_kind = (e_dw && !dbg_we) ? 2 : ((e_cw && !cpu_we) ? 1 : 0);
      m_rd_data = m_mem[e_addr];
      if (e_en && e_we) m_mem[e_addr] = e_wd;
      m_wait   = (dbg_req && !e_dw) ? ((m_wait < SL) ? m_wait + 1 : SL) : 0;
      m_locked = m_locked ? dbg_lock : (e_dw && dbg_lock);
    end
  end

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
    dbg_req = 0; dbg_we = 0; dbg_lock = 0; dbg_addr = '0; dbg_wdata = '0;
  endtask

  // Counts cycles (including the current one) until dbg_gnt; returns at the grant cycle's negedge
  task automatic wait_gnt(output int k);
    bit got;
    got = 0;
    k = 0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      k++;
      if (dbg_gnt === 1'b1) got = 1;
      else next();
    end
    if (!got) begin
      n_vec++;
      n_err++;
      $display("FAIL gnt_timeout @%0t: got no grant in %0d cycles, expected one", $time, k);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int  k, stall_n, cyc_n;
    bit  g, pending, lock_v;

    for (int i = 0; i < (1 << AW); i++) begin
      ram[i]   = init_val(i);
      m_mem[i] = init_val(i);
    end
    ram[3]   = 32'hDEAD_BEEF;
    m_mem[3] = 32'hDEAD_BEEF;

    // Reset with both requesters active
    idle();
    rst_n = 0;
    cpu_req = 1; cpu_addr = 10'h8;
    dbg_req = 1; dbg_addr = 10'h7;
    @(negedge clk);
    check("rst_gnt",    32'(dbg_gnt),    32'd0);
    check("rst_stall",  32'(cpu_stall),  32'd0);
    check("rst_en",     32'(mem_en),     32'd0);
    check("rst_addr",   32'(mem_addr),   32'd0);
    check("rst_rvalid", 32'(dbg_rvalid), 32'd0);
    next();
    rst_n = 1;
    @(negedge clk);
    check("rel_stall", 32'(cpu_stall), 32'd0);
    check("rel_gnt",   32'(dbg_gnt),   32'd0);
    check("rel_addr",  32'(mem_addr),  32'h8);
    next();
    wait_gnt(k);
    check("rel_wait", 32'(k), 32'd4);
    next();
    dbg_req = 0; cpu_req = 0;
    @(negedge clk);
    check("rel_rdata", dbg_rdata, init_val(7));

    // Starvation: debug read of 0x3 against continuous CPU traffic
    next();
    cpu_req = 1; cpu_we = 0; cpu_addr = 10'h40;
    dbg_req = 1; dbg_we = 0; dbg_addr = 10'h3;
    wait_gnt(k);
    check("starve_cycle", 32'(k), 32'd5);
    check("starve_stall", 32'(cpu_stall), 32'd1);
    next();
    dbg_req = 0;
    @(negedge clk);
    check("starve_rvalid", 32'(dbg_rvalid), 32'd1);
    check("starve_rdata",  dbg_rdata, 32'hDEAD_BEEF);

    // Idle CPU: debug write granted at once, CPU load sees it
    next();
    cpu_req = 0;
    dbg_req = 1; dbg_we = 1; dbg_addr = 10'h10; dbg_wdata = 32'h1234_5678;
    @(negedge clk);
    check("idle_gnt", 32'(dbg_gnt), 32'd1);
    next();
    dbg_req = 0; dbg_we = 0;
    cpu_req = 1; cpu_we = 0; cpu_addr = 10'h10;
    @(negedge clk);
    check("idle_ld_stall", 32'(cpu_stall), 32'd0);
    next();
    cpu_req = 0;
    @(negedge clk);
    check("idle_ld_data", cpu_rdata, 32'h1234_5678);

    // Locked burst of 8 writes with gaps while the CPU keeps requesting
    next();
    cpu_req = 1; cpu_we = 0; cpu_addr = 10'h30;
    dbg_req = 1; dbg_we = 1; dbg_lock = 1; dbg_addr = 10'h20; dbg_wdata = 32'hC0DE_0000;
    wait_gnt(k);
    stall_n = 32'(cpu_stall);
    cyc_n = 1;
    for (int i = 1; i < 8; i++) begin
      next();
      if (i % 2 == 1) begin
        dbg_req = 0;
        @(negedge clk);
        check("lock_gap_en", 32'(mem_en), 32'd0);
        stall_n += 32'(cpu_stall);
        cyc_n++;
        next();
      end
      dbg_req = 1; dbg_addr = AW'(10'h20 + i); dbg_wdata = 32'hC0DE_0000 + 32'(i);
      @(negedge clk);
      check("lock_gnt", 32'(dbg_gnt), 32'd1);
      stall_n += 32'(cpu_stall);
      cyc_n++;
    end
    next();
    dbg_req = 0; dbg_lock = 0;
    @(negedge clk);
    stall_n += 32'(cpu_stall);
    cyc_n++;
    check("lock_stalls", 32'(stall_n), 32'd13);
    check("lock_cycles", 32'(cyc_n),   32'd13);
    next();
    @(negedge clk);
    check("unlock_stall", 32'(cpu_stall), 32'd0);
    check("unlock_addr",  32'(mem_addr),  32'h30);
    next();
    cpu_addr = 10'h23;
    @(negedge clk);
    next();
    cpu_req = 0;
    @(negedge clk);
    check("burst_readback", cpu_rdata, 32'hC0DE_0003);

    // Same-address conflict: forced debug store 0xB vs CPU store 0xA at 0x5
    next();
    dbg_req = 1; dbg_we = 1; dbg_addr = 10'h5; dbg_wdata = 32'hB;
    stall_n = 0;
    for (int c = 1; c <= 4; c++) begin
      cpu_req = 1; cpu_we = 1; cpu_addr = AW'(10'h100 + c); cpu_wdata = 32'(c);
      @(negedge clk);
      stall_n += 32'(cpu_stall);
      next();
    end
    cpu_addr = 10'h5; cpu_wdata = 32'hA;
    @(negedge clk);
    check("conf_forced", 32'(dbg_gnt), 32'd1);
    stall_n += 32'(cpu_stall);
    next();
    dbg_req = 0; dbg_we = 0;
    @(negedge clk);
    stall_n += 32'(cpu_stall);
    check("conf_retry_addr",  32'(mem_addr), 32'h5);
    check("conf_retry_wdata", mem_wdata, 32'hA);
    next();
    cpu_req = 0; cpu_we = 0;
    @(negedge clk);
    check("conf_ram", ram[5], 32'hA);
    check("conf_stalls", 32'(stall_n), 32'd1);

    // Reset mid-LOCK right after a granted debug read
    next();
    dbg_req = 1; dbg_we = 0; dbg_lock = 1; dbg_addr = 10'h21;
    @(negedge clk);
    check("mid_lock_gnt", 32'(dbg_gnt), 32'd1);
    next();
    rst_n = 0;
    dbg_addr = 10'h22;
    cpu_req = 1; cpu_we = 0; cpu_addr = 10'h31;
    @(negedge clk);
    check("mid_rst_rvalid", 32'(dbg_rvalid), 32'd0);
    next();
    rst_n = 1;
    @(negedge clk);
    check("post_rst_stall", 32'(cpu_stall), 32'd0);
    check("post_rst_gnt",   32'(dbg_gnt),   32'd0);
    check("post_rst_addr",  32'(mem_addr),  32'h31);
    next();
    wait_gnt(k);
    next();
    idle();

    // Randomised traffic with occasional resets
    pending = 0;
    lock_v = 0;
    g = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (!pending || g) begin
        pending = 0;
        if ($urandom_range(0, 7) == 0) lock_v = !lock_v;
        dbg_lock = lock_v;
        if ($urandom_range(0, 99) < 45) begin
          dbg_req = 1;
          dbg_we = 1'($urandom_range(0, 1));
          dbg_addr = AW'($urandom_range(0, 15));
          dbg_wdata = $urandom;
          pending = 1;
        end else begin
          dbg_req = 0;
        end
      end
      cpu_req = ($urandom_range(0, 99) < 70);
      cpu_we = 1'($urandom_range(0, 1));
      cpu_addr = AW'($urandom_range(0, 15));
      cpu_wdata = $urandom;
      rst_n = ($urandom_range(0, 299) != 0);
      @(negedge clk);
      g = dbg_gnt;
      next();
    end

    rst_n = 1;
    idle();
    next();
    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
